// File: rtl/arb_pkg.sv
// Shared types and constants for the IF/EX memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        EX_BUSY = 2'b10,
        EX_LOCK = 2'b11
    } arb_state_t;

    // Instruction fetches are always 4-byte, one-hot size encoding.
    localparam logic [3:0] IF_FETCH_SIZE = 4'b0100;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of EX grants taken while IF was left waiting.
module arb_starve_cnt #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    assign sat = (cnt_q == W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-BIU arbiter between instruction fetch and execute traffic, with AMO lock.
// Optional IF anti-starvation enabled by defining ARB_STARVE_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_read,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [3:0]        if_priv,
    output logic              if_ready,
    output logic              if_fault,
    input  logic              ex_read,
    input  logic              ex_write,
    input  logic [2:0]        ex_fence,
    input  logic              ex_lock,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [3:0]        ex_size,
    input  logic [3:0]        ex_priv,
    input  logic              ex_unpage,
    input  logic [ADDR_W-1:0] ex_wdata,
    output logic              ex_ready,
    output logic              ex_fault,
    output logic              biu_read,
    output logic              biu_write,
    output logic [2:0]        biu_fence,
    output logic [ADDR_W-1:0] biu_addr,
    output logic [3:0]        biu_size,
    output logic [3:0]        biu_priv,
    output logic              biu_unpage,
    output logic [ADDR_W-1:0] biu_wdata,
    input  logic              biu_ready,
    input  logic              biu_fault
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    arb_state_t state_q, state_d;
    logic       ex_req;
    logic       force_if;

    assign ex_req = ex_read | ex_write | (|ex_fence);

`ifdef ARB_STARVE_EN
    logic starve_sat;
    logic starve_inc;
    logic starve_clr;

    // Count only IDLE grants; the EX_LOCK -> EX_BUSY hop is part of one AMO.
    assign starve_inc = (state_q == IDLE) && (state_d == EX_BUSY) && if_read;
    assign starve_clr = (state_q == IDLE) && (!if_read || (state_d == IF_BUSY));
    assign force_if   = starve_sat & if_read;

    arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat)
    );
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        if_ready   = 1'b0;
        if_fault   = 1'b0;
        ex_ready   = 1'b0;
        ex_fault   = 1'b0;
        biu_read   = 1'b0;
        biu_write  = 1'b0;
        biu_fence  = '0;
        biu_addr   = '0;
        biu_size   = '0;
        biu_priv   = '0;
        biu_unpage = 1'b0;
        biu_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (ex_req && !force_if) begin
                    state_d = EX_BUSY;
                end else if (if_read) begin
                    state_d = IF_BUSY;
                end
            end

            IF_BUSY: begin
                biu_read = 1'b1;
                biu_addr = if_addr;
                biu_size = IF_FETCH_SIZE;
                biu_priv = if_priv;
                if (biu_fault) begin
                    if_fault = 1'b1;
                    state_d  = IDLE;
                end else if (biu_ready) begin
                    if_ready = 1'b1;
                    state_d  = IDLE;
                end
            end

            EX_BUSY: begin
                biu_read   = ex_read;
                biu_write  = ex_write;
                biu_fence  = ex_fence;
                biu_addr   = ex_addr;
                biu_size   = ex_size;
                biu_priv   = ex_priv;
                biu_unpage = ex_unpage;
                biu_wdata  = ex_wdata;
                // Fault beats ready and always abandons the AMO lock.
                if (biu_fault) begin
                    ex_fault = 1'b1;
                    state_d  = IDLE;
                end else if (biu_ready) begin
                    ex_ready = 1'b1;
                    state_d  = ex_lock ? EX_LOCK : IDLE;
                end
            end

            EX_LOCK: begin
                if (ex_req) begin
                    state_d = EX_BUSY;
                end else if (!ex_lock) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter (default build and ARB_STARVE_EN).
module tb_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam logic [AW-1:0] IFA    = 64'h0000_0000_8000_0000;
    localparam logic [AW-1:0] EXA    = 64'h1234_5678_9abc_def0;
    localparam logic [AW-1:0] EXW    = 64'hdead_beef_cafe_f00d;
    localparam logic [3:0]    IFPRIV = 4'b1000;
    localparam logic [3:0]    EXPRIV = 4'b0010;
    localparam logic [3:0]    EXSIZE = 4'b1000;
    localparam logic [1:0]    O_N = 2'd0, O_IF = 2'd1, O_EX = 2'd2;
    localparam int            NV = 28;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_read;
    logic          if_ready, if_fault;
    logic          ex_read, ex_write, ex_lock;
    logic [2:0]    ex_fence;
    logic          ex_ready, ex_fault;
    logic          biu_read, biu_write, biu_unpage;
    logic [2:0]    biu_fence;
    logic [AW-1:0] biu_addr, biu_wdata;
    logic [3:0]    biu_size, biu_priv;
    logic          biu_ready, biu_fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       ir, er, ew;
        logic [2:0] fence;
        logic       lk, rdy, flt;
        logic [1:0] owner;
        logic [8:0] ctl;   // {biu_read, biu_write, biu_fence, if_ready, if_fault, ex_ready, ex_fault}
    } vec_t;

    vec_t vecs[NV];

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_read    (if_read),
        .if_addr    (IFA),
        .if_priv    (IFPRIV),
        .if_ready   (if_ready),
        .if_fault   (if_fault),
        .ex_read    (ex_read),
        .ex_write   (ex_write),
        .ex_fence   (ex_fence),
        .ex_lock    (ex_lock),
        .ex_addr    (EXA),
        .ex_size    (EXSIZE),
        .ex_priv    (EXPRIV),
        .ex_unpage  (1'b1),
        .ex_wdata   (EXW),
        .ex_ready   (ex_ready),
        .ex_fault   (ex_fault),
        .biu_read   (biu_read),
        .biu_write  (biu_write),
        .biu_fence  (biu_fence),
        .biu_addr   (biu_addr),
        .biu_size   (biu_size),
        .biu_priv   (biu_priv),
        .biu_unpage (biu_unpage),
        .biu_wdata  (biu_wdata),
        .biu_ready  (biu_ready),
        .biu_fault  (biu_fault)
    );

    // Requesters must hold their request while they own the bus.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(dut.state_q == arb_pkg::IF_BUSY && !if_read))
                else $error("protocol: if_read dropped while IF owns the BIU");
            assert (!(dut.state_q == arb_pkg::EX_BUSY && !(ex_read || ex_write || (|ex_fence))))
                else $error("protocol: EX request dropped while EX owns the BIU");
        end
    end

    function automatic vec_t mk(input logic ir, er, ew, input logic [2:0] fence,
                                input logic lk, rdy, flt, input logic [1:0] owner,
                                input logic [8:0] ctl);
        vec_t v;
        v.ir = ir; v.er = er; v.ew = ew; v.fence = fence;
        v.lk = lk; v.rdy = rdy; v.flt = flt; v.owner = owner; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input logic [1:0] owner, input logic [8:0] ctl);
        logic [AW-1:0] e_addr, e_wdata;
        logic [8:0]    e_attr;   // {size, priv, unpage}
        case (owner)
            O_IF:    begin e_addr = IFA; e_wdata = '0;  e_attr = {4'b0100, IFPRIV, 1'b0}; end
            O_EX:    begin e_addr = EXA; e_wdata = EXW; e_attr = {EXSIZE, EXPRIV, 1'b1}; end
            default: begin e_addr = '0;  e_wdata = '0;  e_attr = '0; end
        endcase
        chk({nm, " ctl"}, AW'({biu_read, biu_write, biu_fence, if_ready, if_fault, ex_ready, ex_fault}), AW'(ctl));
        chk({nm, " addr"}, biu_addr, e_addr);
        chk({nm, " attr"}, AW'({biu_size, biu_priv, biu_unpage}), AW'(e_attr));
        chk({nm, " wdata"}, biu_wdata, e_wdata);
    endtask

    task automatic drive(input logic ir, er, ew, input logic [2:0] fence, input logic lk, rdy, flt);
        if_read = ir; ex_read = er; ex_write = ew; ex_fence = fence;
        ex_lock = lk; biu_ready = rdy; biu_fault = flt;
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        drive(v.ir, v.er, v.ew, v.fence, v.lk, v.rdy, v.flt);
        #1;
        check_outputs(nm, v.owner, v.ctl);
    endtask

    initial begin
        // IF read, ready on third busy cycle
        vecs[0]  = mk(1,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[1]  = mk(1,0,0,3'b000,0,0,0, O_IF, 9'b1_0_000_0000);
        vecs[2]  = mk(1,0,0,3'b000,0,0,0, O_IF, 9'b1_0_000_0000);
        vecs[3]  = mk(1,0,0,3'b000,0,1,0, O_IF, 9'b1_0_000_1000);
        vecs[4]  = mk(0,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        // IF and EX together: EX first, IF after one dead cycle
        vecs[5]  = mk(1,1,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[6]  = mk(1,1,0,3'b000,0,0,0, O_EX, 9'b1_0_000_0000);
        vecs[7]  = mk(1,1,0,3'b000,0,1,0, O_EX, 9'b1_0_000_0010);
        vecs[8]  = mk(1,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[9]  = mk(1,0,0,3'b000,0,0,0, O_IF, 9'b1_0_000_0000);
        vecs[10] = mk(1,0,0,3'b000,0,1,0, O_IF, 9'b1_0_000_1000);
        vecs[11] = mk(0,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        // AMO read/write through EX_LOCK with IF waiting
        vecs[12] = mk(1,1,0,3'b000,1,0,0, O_N,  9'b0_0_000_0000);
        vecs[13] = mk(1,1,0,3'b000,1,1,0, O_EX, 9'b1_0_000_0010);
        vecs[14] = mk(1,0,1,3'b000,1,0,0, O_N,  9'b0_0_000_0000);
        vecs[15] = mk(1,0,1,3'b000,1,0,0, O_EX, 9'b0_1_000_0000);
        vecs[16] = mk(1,0,1,3'b000,1,1,0, O_EX, 9'b0_1_000_0010);
        vecs[17] = mk(1,0,0,3'b000,1,0,0, O_N,  9'b0_0_000_0000);
        vecs[18] = mk(1,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[19] = mk(1,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[20] = mk(1,0,0,3'b000,0,1,0, O_IF, 9'b1_0_000_1000);
        // Fault (with simultaneous ready) under ex_lock returns to IDLE
        vecs[21] = mk(0,1,0,3'b000,1,0,0, O_N,  9'b0_0_000_0000);
        vecs[22] = mk(0,1,0,3'b000,1,1,1, O_EX, 9'b1_0_000_0001);
        vecs[23] = mk(1,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[24] = mk(1,0,0,3'b000,0,0,1, O_IF, 9'b1_0_000_0100);
        // Fence request, then stray ready/fault in IDLE
        vecs[25] = mk(0,0,0,3'b101,0,0,0, O_N,  9'b0_0_000_0000);
        vecs[26] = mk(0,0,0,3'b101,0,1,0, O_EX, 9'b0_0_101_0010);
        vecs[27] = mk(0,0,0,3'b000,0,1,1, O_N,  9'b0_0_000_0000);

        rst_n = 1'b0;
        drive(1, 1, 0, 3'b000, 0, 1, 0);
        #2;
        check_outputs("reset", O_N, 9'b0);
        @(negedge clk);
        drive(0, 0, 0, 3'b000, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i], $sformatf("row%0d", i));
        end

        // Asynchronous reset in the middle of an EX write
        step(mk(0,0,1,3'b000,0,0,0, O_N,  9'b0_0_000_0000), "rst_pre");
        step(mk(0,0,1,3'b000,0,0,0, O_EX, 9'b0_1_000_0000), "rst_busy");
        #1;
        rst_n     = 1'b0;
        biu_ready = 1'b1;
        #1;
        check_outputs("rst_async", O_N, 9'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        biu_ready = 1'b0;
        #1;
        check_outputs("rst_release", O_N, 9'b0);
        step(mk(0,0,1,3'b000,0,1,0, O_EX, 9'b0_1_000_0010), "rst_regrant");
        step(mk(0,0,0,3'b000,0,0,0, O_N,  9'b0_0_000_0000), "rst_done");

        // Continuous IF + EX demand: strict EX priority, or IF forced every 5th grant
        for (int k = 0; k < 10; k++) begin
            logic [1:0] own;
`ifdef ARB_STARVE_EN
            own = (k % 5 == 4) ? O_IF : O_EX;
`else
            own = O_EX;
`endif
            step(mk(1,1,0,3'b000,0,0,0, O_N, 9'b0), $sformatf("starve%0d_idle", k));
            step(mk(1,1,0,3'b000,0,1,0, own,
                    (own == O_IF) ? 9'b1_0_000_1000 : 9'b1_0_000_0010),
                 $sformatf("starve%0d_grant", k));
        end
        step(mk(0,0,0,3'b000,0,0,0, O_N, 9'b0), "final_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
